// File: rtl/mod_exp_pkg.sv
// rtl/mod_exp_pkg.sv - shared widths, engine bound and FSM state encodings for mod_exp_initiator
package mod_exp_pkg;

    localparam int MOD_EXP_W      = 256;
    localparam int MOD_EXP_E_BITS = 256;
    localparam int MOD_EXP_K_CFG  = MOD_EXP_W - 2;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE     = 3'd0;
    localparam state_t S_CHECK    = 3'd1;
    localparam state_t S_MUL_REQ  = 3'd2;
    localparam state_t S_MUL_WAIT = 3'd3;
    localparam state_t S_SQR_REQ  = 3'd4;
    localparam state_t S_SQR_WAIT = 3'd5;
    localparam state_t S_DONE     = 3'd6;

endpackage

// File: rtl/mod_exp_initiator.sv
// rtl/mod_exp_initiator.sv - right-to-left square-and-multiply requester; MOD_EXP_EARLY_TERM_EN stops once the exponent is exhausted
module mod_exp_initiator
    import mod_exp_pkg::*;
#(
    parameter int W      = MOD_EXP_W,
    parameter int E_BITS = MOD_EXP_E_BITS,
    parameter int K_CFG  = W - 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [W-1:0]      i_base,
    input  logic [E_BITS-1:0] i_exp,
    input  logic [W-1:0]      i_N,
    output logic              o_busy,
    output logic              o_done,
    output logic [W-1:0]      o_result,
    output logic              o_mp_valid,
    output logic [W-1:0]      o_mp_N,
    output logic [W-1:0]      o_mp_a,
    output logic [W-1:0]      o_mp_b,
    output logic [8:0]        o_mp_k,
    input  logic              i_mp_ready,
    input  logic [W-1:0]      i_mp_product
);

    localparam int                IDX_W    = $clog2(E_BITS) + 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(E_BITS - 1);
    localparam logic [W-1:0]      ONE      = W'(1);

    state_t              state;
    logic [W-1:0]        base_r;
    logic [W-1:0]        res_r;
    logic [E_BITS-1:0]   e_sh;
    logic [IDX_W-1:0]    idx;

    assign o_mp_k = 9'(K_CFG);

    // Operands are loaded on the edge entering a REQ state and then left alone,
    // so the engine sees them unchanged until its ready pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            base_r     <= '0;
            res_r      <= '0;
            e_sh       <= '0;
            idx        <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_result   <= '0;
            o_mp_valid <= 1'b0;
            o_mp_N     <= '0;
            o_mp_a     <= '0;
            o_mp_b     <= '0;
        end else begin
            o_mp_valid <= 1'b0;
            o_done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        o_mp_N <= i_N;
                        base_r <= i_base;
                        e_sh   <= i_exp;
                        res_r  <= ONE;
                        idx    <= '0;
                        o_busy <= 1'b1;
                        state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
`ifdef MOD_EXP_EARLY_TERM_EN
                    if (e_sh == '0) begin
                        o_result <= res_r;
                        o_done   <= 1'b1;
                        state    <= S_DONE;
                    end else
`endif
                    if (e_sh[0]) begin
                        o_mp_valid <= 1'b1;
                        o_mp_a     <= res_r;
                        o_mp_b     <= base_r;
                        state      <= S_MUL_REQ;
                    end else begin
                        o_mp_valid <= 1'b1;
                        o_mp_a     <= base_r;
                        o_mp_b     <= base_r;
                        state      <= S_SQR_REQ;
                    end
                end
                S_MUL_REQ: state <= S_MUL_WAIT;
                S_MUL_WAIT: begin
                    if (i_mp_ready) begin
                        res_r      <= i_mp_product;
                        o_mp_valid <= 1'b1;
                        o_mp_a     <= base_r;
                        o_mp_b     <= base_r;
                        state      <= S_SQR_REQ;
                    end
                end
                S_SQR_REQ: state <= S_SQR_WAIT;
                S_SQR_WAIT: begin
                    if (i_mp_ready) begin
                        base_r <= i_mp_product;
                        e_sh   <= e_sh >> 1;
                        idx    <= idx + IDX_W'(1);
                        if (idx == IDX_LAST) begin
                            o_result <= res_r;
                            o_done   <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            state <= S_CHECK;
                        end
                    end
                end
                S_DONE: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp_initiator.sv
// tb/tb_mod_exp_initiator.sv - scoreboard bench for mod_exp_initiator with a random-latency engine model
module tb_mod_exp_initiator;
    import mod_exp_pkg::*;

    localparam int W  = 256;
    localparam int EB = 256;
`ifdef MOD_EXP_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic           i_clk = 1'b0;
    logic           i_rst_n;
    logic           i_start;
    logic [W-1:0]   i_base;
    logic [EB-1:0]  i_exp;
    logic [W-1:0]   i_N;
    logic           o_busy, o_done, o_mp_valid;
    logic [W-1:0]   o_result, o_mp_N, o_mp_a, o_mp_b;
    logic [8:0]     o_mp_k;
    logic           i_mp_ready;
    logic [W-1:0]   i_mp_product;

    logic           eng_ready, eng_busy, spur_ready;
    logic [W-1:0]   eng_prod, spur_prod, cap_a, cap_b, cap_n;
    int             eng_cnt;

    int             n_tests = 0;
    int             n_fail = 0;
    int             pulse_cnt = 0;
    int             viol_cnt = 0;
    logic [W-1:0]   exp_q[$];

    assign i_mp_ready   = eng_ready | spur_ready;
    assign i_mp_product = spur_ready ? spur_prod : eng_prod;

    mod_exp_initiator #(.W(W), .E_BITS(EB), .K_CFG(W - 2)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
        .i_base(i_base), .i_exp(i_exp), .i_N(i_N),
        .o_busy(o_busy), .o_done(o_done), .o_result(o_result),
        .o_mp_valid(o_mp_valid), .o_mp_N(o_mp_N), .o_mp_a(o_mp_a),
        .o_mp_b(o_mp_b), .o_mp_k(o_mp_k),
        .i_mp_ready(i_mp_ready), .i_mp_product(i_mp_product)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] n);
        logic [2*W-1:0] p;
        p = (2*W)'(a) * (2*W)'(b);
        return W'(p % (2*W)'(n));
    endfunction

    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [EB-1:0] e,
                                                 input logic [W-1:0] n);
        logic [W-1:0] r;
        logic [W-1:0] bb;
        r  = W'(1);
        bb = b;
        for (int i = 0; i < EB; i++) begin
            if (e[i]) r = mulmod(r, bb, n);
            bb = mulmod(bb, bb, n);
        end
        return r;
    endfunction

    function automatic int ref_pulses(input logic [EB-1:0] e);
        int ones;
        int hi;
        ones = 0;
        hi   = -1;
        for (int i = 0; i < EB; i++) begin
            if (e[i]) begin
                ones++;
                hi = i;
            end
        end
        return ET ? ones + hi + 1 : ones + EB;
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic int pick_lat();
        if ($urandom_range(0, 15) == 0) return int'($urandom_range(3, 300));
        return int'($urandom_range(3, 8));
    endfunction

    // Behavioural modulo-product engine: accepts valid only when idle, answers after a random delay.
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            eng_busy  <= 1'b0;
            eng_ready <= 1'b0;
            eng_cnt   <= 0;
            eng_prod  <= '0;
        end else begin
            eng_ready <= 1'b0;
            if (eng_busy) begin
                if (eng_cnt <= 1) begin
                    eng_ready <= 1'b1;
                    eng_busy  <= 1'b0;
                end else begin
                    eng_cnt <= eng_cnt - 1;
                end
            end else if (o_mp_valid && !eng_ready) begin
                eng_busy <= 1'b1;
                eng_cnt  <= pick_lat();
                cap_a    <= o_mp_a;
                cap_b    <= o_mp_b;
                cap_n    <= o_mp_N;
                eng_prod <= mulmod(o_mp_a, o_mp_b, o_mp_N);
            end
        end
    end

    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_mp_valid) pulse_cnt++;
            if (o_mp_valid && i_mp_ready) begin
                viol_cnt++;
                $display("[TB] protocol violation: valid and ready together at %0t", $time);
            end
            if (eng_ready && (o_mp_a !== cap_a || o_mp_b !== cap_b || o_mp_N !== cap_n)) begin
                viol_cnt++;
                $display("[TB] protocol violation: operands moved before ready at %0t", $time);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    // inject: 0 none, 1 second start while the first multiply is pending, 2 spurious ready in S_CHECK
    task automatic drive_op(input logic [W-1:0] b, input logic [EB-1:0] e, input logic [W-1:0] n,
                            input logic [W-1:0] expv, input int inject,
                            output logic got, output logic [W-1:0] res, output logic [W-1:0] want,
                            output int cyc, output logic busy_ok, output logic done_single,
                            output logic idle_after, output int pulses);
        int  p0;
        logic injected;
        p0 = pulse_cnt;
        exp_q.push_back(expv);
        @(posedge i_clk); #1;
        i_start = 1'b1; i_base = b; i_exp = e; i_N = n;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        if (inject == 2) begin
            spur_ready = 1'b1;
            spur_prod  = W'(3);
            @(posedge i_clk); #1;
            spur_ready = 1'b0;
        end
        got = 1'b0; busy_ok = 1'b1; cyc = 0; injected = 1'b0;
        while (!got && cyc < 20000) begin
            @(negedge i_clk);
            cyc++;
            if (o_done) begin
                got = 1'b1;
            end else begin
                if (o_busy !== 1'b1) busy_ok = 1'b0;
                if (inject == 1 && !injected && o_mp_valid) begin
                    injected = 1'b1;
                    @(posedge i_clk); #1;
                    i_start = 1'b1; i_base = W'(7); i_exp = EB'(5); i_N = W'(11);
                    @(posedge i_clk); #1;
                    i_start = 1'b0;
                end
            end
        end
        res  = o_result;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        @(negedge i_clk);
        done_single = (o_done === 1'b0);
        idle_after  = (o_busy === 1'b0) && (o_result === res);
        pulses      = pulse_cnt - p0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_start = 1'b0; i_base = '0; i_exp = '0; i_N = '0;
        spur_ready = 1'b0; spur_prod = '0;
        repeat (3) @(negedge i_clk);
        n_tests++; if ({o_busy, o_done, o_mp_valid} !== 3'b000) begin
            n_fail++; $display("[TB] FAIL reset_flags: got %b required 000", {o_busy, o_done, o_mp_valid});
        end
        n_tests++; if (o_result !== '0) begin
            n_fail++; $display("[TB] FAIL reset_result: got %h required 0", o_result);
        end
        n_tests++; if ((o_mp_a | o_mp_b | o_mp_N) !== '0) begin
            n_fail++; $display("[TB] FAIL reset_operands: a=%h b=%h N=%h required 0", o_mp_a, o_mp_b, o_mp_N);
        end
        n_tests++; if (o_mp_k !== 9'(MOD_EXP_K_CFG)) begin
            n_fail++; $display("[TB] FAIL mp_k: got %0d required %0d", o_mp_k, MOD_EXP_K_CFG);
        end
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic got, bo, ds, ia; logic [W-1:0] r, w; int c, p;
        drive_op(W'(5), EB'(3), W'(13), W'(8), 0, got, r, w, c, bo, ds, ia, p);
        n_tests++; if (!got) begin n_fail++; $display("[TB] FAIL basic_done: no o_done, required o_done"); end
        n_tests++; if (r !== w) begin n_fail++; $display("[TB] FAIL basic_result: got %0d required %0d", r, w); end
        n_tests++; if (p !== (ET ? 4 : 258)) begin
            n_fail++; $display("[TB] FAIL basic_pulses: got %0d required %0d", p, ET ? 4 : 258);
        end
    endtask

    task automatic test_busy_pulse();
        logic got, bo, ds, ia; logic [W-1:0] r, w; int c, p;
        drive_op(W'(2), EB'(10), W'(1000), W'(24), 0, got, r, w, c, bo, ds, ia, p);
        n_tests++; if (r !== w) begin n_fail++; $display("[TB] FAIL pow_result: got %0d required %0d", r, w); end
        n_tests++; if (!bo) begin n_fail++; $display("[TB] FAIL busy_held: got busy drop required 1 throughout"); end
        n_tests++; if (!ds) begin n_fail++; $display("[TB] FAIL done_pulse: got o_done=1 next cycle required 0"); end
        n_tests++; if (!ia) begin n_fail++; $display("[TB] FAIL idle_after: got busy=%b result=%0d required 0/%0d", o_busy, o_result, w); end
        n_tests++; if (p !== ref_pulses(EB'(10))) begin
            n_fail++; $display("[TB] FAIL pow_pulses: got %0d required %0d", p, ref_pulses(EB'(10)));
        end
    endtask

    task automatic test_exp_zero();
        logic got, bo, ds, ia, lat_ok; logic [W-1:0] r, w; int c, p;
        drive_op(W'(9), EB'(0), W'(13), W'(1), 0, got, r, w, c, bo, ds, ia, p);
        lat_ok = ET ? (c == 2) : (c >= 5 * EB);
        n_tests++; if (r !== w) begin n_fail++; $display("[TB] FAIL zero_result: got %0d required %0d", r, w); end
        n_tests++; if (p !== (ET ? 0 : 256)) begin
            n_fail++; $display("[TB] FAIL zero_pulses: got %0d required %0d", p, ET ? 0 : 256);
        end
        n_tests++; if (!lat_ok) begin
            n_fail++; $display("[TB] FAIL zero_latency: got %0d cycles required %s", c, ET ? "2" : ">=1280");
        end
    endtask

    task automatic test_start_ignored();
        logic got, bo, ds, ia; logic [W-1:0] r, w; int c, p;
        drive_op(W'(5), EB'(3), W'(13), W'(8), 1, got, r, w, c, bo, ds, ia, p);
        n_tests++; if (r !== w) begin n_fail++; $display("[TB] FAIL ignore_start_result: got %0d required %0d", r, w); end
        n_tests++; if (!ia || p !== (ET ? 4 : 258)) begin
            n_fail++; $display("[TB] FAIL ignore_start_idle: got busy=%b pulses=%0d required 0/%0d", o_busy, p, ET ? 4 : 258);
        end
    endtask

    task automatic test_spurious_ready();
        logic got, bo, ds, ia; logic [W-1:0] r, w; int c, p;
        drive_op(W'(5), EB'(3), W'(13), W'(8), 2, got, r, w, c, bo, ds, ia, p);
        n_tests++; if (r !== w) begin n_fail++; $display("[TB] FAIL spurious_ready_result: got %0d required %0d", r, w); end
        n_tests++; if (p !== (ET ? 4 : 258)) begin
            n_fail++; $display("[TB] FAIL spurious_ready_pulses: got %0d required %0d", p, ET ? 4 : 258);
        end
    endtask

    task automatic test_reset_mid();
        logic got, bo, ds, ia, seen; logic [W-1:0] r, w; int c, p;
        exp_q.push_back(W'(24));
        @(posedge i_clk); #1;
        i_start = 1'b1; i_base = W'(2); i_exp = EB'(10); i_N = W'(1000);
        @(posedge i_clk); #1;
        i_start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge i_clk);
            seen = o_mp_valid;
        end
        n_tests++; if (!seen) begin n_fail++; $display("[TB] FAIL mid_reset_req: no request seen, required o_mp_valid"); end
        @(posedge i_clk); #2;
        i_rst_n = 1'b0;
        #1;
        n_tests++; if ({o_busy, o_done, o_mp_valid} !== 3'b000 || (o_result | o_mp_a | o_mp_b | o_mp_N) !== '0) begin
            n_fail++; $display("[TB] FAIL mid_reset_outputs: busy=%b done=%b valid=%b result=%0d a=%0d b=%0d N=%0d required all 0",
                               o_busy, o_done, o_mp_valid, o_result, o_mp_a, o_mp_b, o_mp_N);
        end
        exp_q.delete();
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        drive_op(W'(2), EB'(10), W'(1000), W'(24), 0, got, r, w, c, bo, ds, ia, p);
        n_tests++; if (r !== w) begin n_fail++; $display("[TB] FAIL after_reset_result: got %0d required %0d", r, w); end
    endtask

    task automatic test_random();
        logic got, bo, ds, ia; logic [W-1:0] r, w, n, b, msb; logic [EB-1:0] e; int c, p;
        msb = '0;
        msb[W-1] = 1'b1;
        for (int t = 0; t < 2; t++) begin
            n = rand_w() | msb | W'(1);
            b = rand_w() % n;
            e = (t == 0) ? EB'(rand_w()) : EB'($urandom);
            drive_op(b, e, n, ref_modexp(b, e, n), 0, got, r, w, c, bo, ds, ia, p);
            n_tests++; if (r !== w) begin n_fail++; $display("[TB] FAIL random_result[%0d]: got %h required %h", t, r, w); end
            n_tests++; if (p !== ref_pulses(e)) begin
                n_fail++; $display("[TB] FAIL random_pulses[%0d]: got %0d required %0d", t, p, ref_pulses(e));
            end
        end
    endtask

    task automatic test_protocol();
        n_tests++; if (viol_cnt !== 0) begin
            n_fail++; $display("[TB] FAIL protocol: got %0d violations required 0", viol_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_busy_pulse();
        test_exp_zero();
        test_start_ignored();
        test_spurious_ready();
        test_reset_mid();
        test_random();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
